// File: rtl/host_cfg_pkg.sv
// rtl/host_cfg_pkg.sv - shared sizing for the host configuration packer
`ifndef H_C_W
`define H_C_W 72
`endif

package host_cfg_pkg;

  localparam int BEAT_W_DEF = 32;
  localparam int H_C_W_DEF  = `H_C_W;

  function automatic int calc_nb(input int hcw, input int bw);
    return (hcw + bw - 1) / bw;
  endfunction

  // A one-beat frame still needs a 1-bit counter to keep widths legal.
  function automatic int calc_cnt_w(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

  localparam int NB    = calc_nb(H_C_W_DEF, BEAT_W_DEF);
  localparam int CNT_W = calc_cnt_w(NB);

endpackage

// File: rtl/host_config_packer_if.sv
// rtl/host_config_packer_if.sv - beat input and frame output handshakes of the packer
`ifndef H_C_W
`define H_C_W 72
`endif

interface host_config_packer_if
  import host_cfg_pkg::*;
#(
  parameter int H_C_W  = `H_C_W,
  parameter int BEAT_W = BEAT_W_DEF
);

  logic              beat_valid;
  logic              beat_ready;
  logic [BEAT_W-1:0] beat_data;
  logic              beat_parity;
  logic              flush;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [H_C_W-1:0]  Host_Config;
  logic              cfg_err;

  modport master (
    output beat_valid, beat_data, beat_parity, flush, cfg_ready,
    input  beat_ready, cfg_valid, Host_Config, cfg_err
  );

  modport slave (
    input  beat_valid, beat_data, beat_parity, flush, cfg_ready,
    output beat_ready, cfg_valid, Host_Config, cfg_err
  );

endinterface

// File: rtl/host_cfg_parity_chk.sv
// rtl/host_cfg_parity_chk.sv - even-parity check of one configuration beat
module host_cfg_parity_chk
  import host_cfg_pkg::*;
#(
  parameter int BEAT_W = BEAT_W_DEF
) (
  input  logic [BEAT_W-1:0] i_beat_data,
  input  logic              i_beat_parity,
  output logic              o_err
);

  assign o_err = (^i_beat_data) ^ i_beat_parity;

endmodule

// File: rtl/host_config_packer.sv
// rtl/host_config_packer.sv - packs narrow host beats into the wide configuration word
// Optional beat parity checking is enabled with HOST_CFG_PARITY_EN.
`ifndef H_C_W
`define H_C_W 72
`endif

module host_config_packer
  import host_cfg_pkg::*;
#(
  parameter int H_C_W  = `H_C_W,
  parameter int BEAT_W = BEAT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  host_config_packer_if.slave  bus
);

  localparam int            NBEATS = calc_nb(H_C_W, BEAT_W);
  localparam int            CW     = calc_cnt_w(NBEATS);
  localparam int            FW     = NBEATS * BEAT_W;
  localparam logic [CW-1:0] LAST   = CW'(NBEATS - 1);

  logic [CW-1:0]    r_cnt;
  logic [FW-1:0]    r_asm;
  logic [H_C_W-1:0] r_host_config;
  logic             r_cfg_valid;

  logic             w_last;
  logic             w_beat_ready;
  logic             w_accept;
  logic             w_final;
  logic             w_frame_bad;
  logic             w_load;
  logic             w_cfg_err;
  logic             w_unused;
  logic [FW:0]      w_frame;

  assign w_last       = (r_cnt == LAST);
  // Only the final beat stalls, and only while the previous frame is still held.
  assign w_beat_ready = !(w_last && r_cfg_valid && !bus.cfg_ready) && !bus.flush;
  assign w_accept     = bus.beat_valid && w_beat_ready;
  assign w_final      = w_accept && w_last;
  assign w_load       = w_final && !w_frame_bad;

  always_comb begin
    w_frame = {1'b0, r_asm};
    w_frame[FW-BEAT_W +: BEAT_W] = bus.beat_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_asm         <= '0;
      r_cfg_valid   <= 1'b0;
      r_host_config <= '0;
    end else begin
      if (bus.flush) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        r_asm[int'(r_cnt) * BEAT_W +: BEAT_W] <= bus.beat_data;
      end
      if (w_load) begin
        r_cfg_valid   <= 1'b1;
        r_host_config <= w_frame[H_C_W-1:0];
      end else if (bus.cfg_ready) begin
        r_cfg_valid <= 1'b0;
      end
    end
  end

`ifdef HOST_CFG_PARITY_EN
  logic w_par_err;
  logic r_bad;
  logic r_cfg_err;

  host_cfg_parity_chk #(.BEAT_W(BEAT_W)) u_parity_chk (
    .i_beat_data   (bus.beat_data),
    .i_beat_parity (bus.beat_parity),
    .o_err         (w_par_err)
  );

  // The final beat's own parity counts toward the frame verdict.
  assign w_frame_bad = r_bad || w_par_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bad     <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_final && w_frame_bad;
      if (bus.flush || w_final) begin
        r_bad <= 1'b0;
      end else if (w_accept && w_par_err) begin
        r_bad <= 1'b1;
      end
    end
  end

  assign w_cfg_err = r_cfg_err;
  assign w_unused  = ^{w_frame[FW:H_C_W], r_asm[FW-1 -: BEAT_W]};
`else
  assign w_frame_bad = 1'b0;
  assign w_cfg_err   = 1'b0;
  assign w_unused    = ^{w_frame[FW:H_C_W], r_asm[FW-1 -: BEAT_W], bus.beat_parity};
`endif

  assign bus.beat_ready  = w_beat_ready;
  assign bus.cfg_valid   = r_cfg_valid;
  assign bus.Host_Config = r_host_config;
  assign bus.cfg_err     = w_cfg_err;

endmodule

// File: tb/tb_host_config_packer.sv
// tb/tb_host_config_packer.sv - directed self-checking bench for host_config_packer
module tb_host_config_packer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  localparam logic [71:0] F_BASIC = 72'hAB_22222222_11111111;
  localparam logic [71:0] F_A     = 72'h33_02020202_01010101;
  localparam logic [71:0] F_B     = 72'h66_05050505_04040404;
  localparam logic [71:0] F_FLUSH = 72'h0C_0000000B_0000000A;
  localparam logic [71:0] F_RST   = 72'h03_00000002_00000001;
  localparam logic [71:0] F_1     = 72'hC1_B1B1B1B1_A1A1A1A1;
  localparam logic [71:0] F_2     = 72'hC2_B2B2B2B2_A2A2A2A2;
  localparam logic [71:0] F_PAR   = 72'hEE_87654321_12345678;
  localparam logic [71:0] F_GOOD  = 72'h0F_0000000E_0000000D;

  host_config_packer_if #(.H_C_W(72), .BEAT_W(32)) bus ();

  host_config_packer #(.H_C_W(72), .BEAT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] d);
    bus.beat_valid  = 1'b1;
    bus.beat_data   = d;
    bus.beat_parity = ^d;
  endtask

  task automatic idle;
    bus.beat_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle();
    bus.flush     = 1'b0;
    bus.cfg_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.beat_ready !== 1'b1) begin errors++; $display("FAIL reset_beat_ready got %b exp 1", bus.beat_ready); end
    checks++; if (bus.cfg_valid !== 1'b0) begin errors++; $display("FAIL reset_cfg_valid got %b exp 0", bus.cfg_valid); end
    checks++; if (bus.Host_Config !== 72'h0) begin errors++; $display("FAIL reset_host_config got %h exp 0", bus.Host_Config); end
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %b exp 0", bus.cfg_err); end
  endtask

  task automatic test_basic;
    bus.cfg_ready = 1'b1;
    put(32'h11111111); tick();
    put(32'h22222222); tick();
    put(32'h000000AB);
    checks++; if (bus.beat_ready !== 1'b1) begin errors++; $display("FAIL basic_last_ready got %b exp 1", bus.beat_ready); end
    checks++; if (bus.cfg_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", bus.cfg_valid); end
    tick();
    idle();
    checks++; if (bus.cfg_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", bus.cfg_valid); end
    checks++; if (bus.Host_Config !== F_BASIC) begin errors++; $display("FAIL basic_data got %h exp %h", bus.Host_Config, F_BASIC); end
    tick();
    checks++; if (bus.cfg_valid !== 1'b0) begin errors++; $display("FAIL basic_handoff got %b exp 0", bus.cfg_valid); end
    checks++; if (bus.Host_Config !== F_BASIC) begin errors++; $display("FAIL basic_hold got %h exp %h", bus.Host_Config, F_BASIC); end
  endtask

  task automatic test_backpressure;
    bus.cfg_ready = 1'b0;
    put(32'h01010101); tick();
    put(32'h02020202); tick();
    put(32'h00000033); tick();
    checks++; if (bus.cfg_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_a got %b exp 1", bus.cfg_valid); end
    checks++; if (bus.Host_Config !== F_A) begin errors++; $display("FAIL bp_data_a got %h exp %h", bus.Host_Config, F_A); end
    put(32'h04040404);
    checks++; if (bus.beat_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_b0 got %b exp 1", bus.beat_ready); end
    tick();
    put(32'h05050505);
    checks++; if (bus.beat_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_b1 got %b exp 1", bus.beat_ready); end
    tick();
    put(32'h00000066);
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.beat_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_%0d got %b exp 0", i, bus.beat_ready); end
      tick();
    end
    checks++; if (bus.Host_Config !== F_A) begin errors++; $display("FAIL bp_held_a got %h exp %h", bus.Host_Config, F_A); end
    bus.cfg_ready = 1'b1;
    #1;
    checks++; if (bus.beat_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", bus.beat_ready); end
    tick();
    idle();
    checks++; if (bus.cfg_valid !== 1'b1) begin errors++; $display("FAIL bp_nogap_valid got %b exp 1", bus.cfg_valid); end
    checks++; if (bus.Host_Config !== F_B) begin errors++; $display("FAIL bp_data_b got %h exp %h", bus.Host_Config, F_B); end
    tick();
    checks++; if (bus.cfg_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", bus.cfg_valid); end
  endtask

  task automatic test_flush;
    bus.cfg_ready = 1'b1;
    put(32'h55555555); tick();
    put(32'h66666666); tick();
    bus.flush = 1'b1;
    put(32'h77777777);
    #1;
    checks++; if (bus.beat_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", bus.beat_ready); end
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.cfg_valid !== 1'b0) begin errors++; $display("FAIL flush_no_accept got %b exp 0", bus.cfg_valid); end
    put(32'h0000000A); tick();
    checks++; if (bus.cfg_valid !== 1'b0) begin errors++; $display("FAIL flush_early_0 got %b exp 0", bus.cfg_valid); end
    put(32'h0000000B); tick();
    checks++; if (bus.cfg_valid !== 1'b0) begin errors++; $display("FAIL flush_early_1 got %b exp 0", bus.cfg_valid); end
    put(32'h0000000C); tick();
    idle();
    checks++; if (bus.cfg_valid !== 1'b1) begin errors++; $display("FAIL flush_valid got %b exp 1", bus.cfg_valid); end
    checks++; if (bus.Host_Config !== F_FLUSH) begin errors++; $display("FAIL flush_data got %h exp %h", bus.Host_Config, F_FLUSH); end
    tick();
  endtask

  task automatic test_reset_mid;
    bus.cfg_ready = 1'b1;
    put(32'h99999999); tick();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    checks++; if (bus.cfg_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", bus.cfg_valid); end
    checks++; if (bus.Host_Config !== 72'h0) begin errors++; $display("FAIL rstmid_host_config got %h exp 0", bus.Host_Config); end
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL rstmid_cfg_err got %b exp 0", bus.cfg_err); end
    #1;
    checks++; if (bus.beat_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", bus.beat_ready); end
    put(32'h00000001); tick();
    put(32'h00000002); tick();
    put(32'h00000003); tick();
    idle();
    checks++; if (bus.cfg_valid !== 1'b1) begin errors++; $display("FAIL rstmid_frame_valid got %b exp 1", bus.cfg_valid); end
    checks++; if (bus.Host_Config !== F_RST) begin errors++; $display("FAIL rstmid_frame_data got %h exp %h", bus.Host_Config, F_RST); end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [31:0] beats [6];
    beats = '{32'hA1A1A1A1, 32'hB1B1B1B1, 32'hDEADBEC1,
              32'hA2A2A2A2, 32'hB2B2B2B2, 32'h000000C2};
    bus.cfg_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      put(beats[i]);
      checks++; if (bus.beat_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got %b exp 1", i, bus.beat_ready); end
      tick();
      if (i == 2) begin
        checks++; if (bus.Host_Config !== F_1) begin errors++; $display("FAIL b2b_data_1 got %h exp %h", bus.Host_Config, F_1); end
        checks++; if (bus.cfg_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_1 got %b exp 1", bus.cfg_valid); end
      end
      if (i == 3) begin
        checks++; if (bus.cfg_valid !== 1'b0) begin errors++; $display("FAIL b2b_clear got %b exp 0", bus.cfg_valid); end
      end
    end
    idle();
    checks++; if (bus.cfg_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_2 got %b exp 1", bus.cfg_valid); end
    checks++; if (bus.Host_Config !== F_2) begin errors++; $display("FAIL b2b_data_2 got %h exp %h", bus.Host_Config, F_2); end
    tick();
  endtask

  task automatic test_parity;
    bus.cfg_ready = 1'b1;
    put(32'h12345678); tick();
    put(32'h87654321);
    bus.beat_parity = ~bus.beat_parity;
    tick();
    put(32'h000000EE); tick();
    idle();
`ifdef HOST_CFG_PARITY_EN
    checks++; if (bus.cfg_valid !== 1'b0) begin errors++; $display("FAIL par_drop_valid got %b exp 0", bus.cfg_valid); end
    checks++; if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL par_err_pulse got %b exp 1", bus.cfg_err); end
    checks++; if (bus.Host_Config !== F_2) begin errors++; $display("FAIL par_held got %h exp %h", bus.Host_Config, F_2); end
    tick();
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL par_err_once got %b exp 0", bus.cfg_err); end
    put(32'h0000000D); tick();
    put(32'h0000000E); tick();
    put(32'h0000000F); tick();
    idle();
    checks++; if (bus.cfg_valid !== 1'b1) begin errors++; $display("FAIL par_good_valid got %b exp 1", bus.cfg_valid); end
    checks++; if (bus.Host_Config !== F_GOOD) begin errors++; $display("FAIL par_good_data got %h exp %h", bus.Host_Config, F_GOOD); end
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL par_good_err got %b exp 0", bus.cfg_err); end
`else
    checks++; if (bus.cfg_valid !== 1'b1) begin errors++; $display("FAIL nopar_valid got %b exp 1", bus.cfg_valid); end
    checks++; if (bus.Host_Config !== F_PAR) begin errors++; $display("FAIL nopar_data got %h exp %h", bus.Host_Config, F_PAR); end
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL nopar_err got %b exp 0", bus.cfg_err); end
`endif
    tick();
  endtask

  initial begin
    bus.beat_valid  = 1'b0;
    bus.beat_data   = '0;
    bus.beat_parity = 1'b0;
    bus.flush       = 1'b0;
    bus.cfg_ready   = 1'b0;
    rst             = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
